// File: rtl/axil_reg_arbiter.sv
// Two-port round-robin arbiter that runs one AXI4-Lite single-word transaction at a time.
// Latency: 3 cycles from request sample to REQn_DONE with a zero-wait slave; next grant the cycle after DONE.
// Backpressure: requesters hold REQn_VALID until DONE; AXI valids are held until their own handshake.
module axil_reg_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,

    input  logic                          REQ0_VALID,
    input  logic                          REQ0_WE,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   REQ0_ADDR,
    input  logic [C_AXI_DATA_WIDTH-1:0]   REQ0_WDATA,
    output logic                          REQ0_DONE,
    output logic [C_AXI_DATA_WIDTH-1:0]   REQ0_RDATA,
    output logic [1:0]                    REQ0_RESP,

    input  logic                          REQ1_VALID,
    input  logic                          REQ1_WE,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   REQ1_ADDR,
    input  logic [C_AXI_DATA_WIDTH-1:0]   REQ1_WDATA,
    output logic                          REQ1_DONE,
    output logic [C_AXI_DATA_WIDTH-1:0]   REQ1_RDATA,
    output logic [1:0]                    REQ1_RESP,

    output logic                          BUSY,

    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                        state_q, state_d;
    logic                          gnt_q, gnt_d;      // requester owning the current transaction
    logic                          last_q, last_d;    // requester granted most recently
    logic                          we_q, we_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic [C_AXI_DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]                    resp0_q, resp0_d, resp1_q, resp1_d;

    logic                          sel;
    logic                          sel_we;
    logic [C_AXI_ADDR_WIDTH-1:0]   sel_addr;
    logic [C_AXI_DATA_WIDTH-1:0]   sel_wdata;

    // Byte-lane bits of the request address never reach the bus.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{REQ0_ADDR[1:0], REQ1_ADDR[1:0]};

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        sel = 1'b0;
        if (REQ0_VALID && REQ1_VALID) begin
            sel = ~last_q;
        end else if (REQ1_VALID) begin
            sel = 1'b1;
        end
        sel_we    = sel ? REQ1_WE    : REQ0_WE;
        sel_addr  = sel ? REQ1_ADDR  : REQ0_ADDR;
        sel_wdata = sel ? REQ1_WDATA : REQ0_WDATA;
    end

    // Sequencer next-state: grant, drive one AXI transaction, capture the result into the owner's registers.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        resp0_d   = resp0_q;
        resp1_d   = resp1_q;

        case (state_q)
            IDLE: begin
                if (REQ0_VALID || REQ1_VALID) begin
                    gnt_d   = sel;
                    we_d    = sel_we;
                    addr_d  = {sel_addr[C_AXI_ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = sel_wdata;
                    if (sel_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                // AW and W retire independently; move on once neither is still pending.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)    state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    if (gnt_q) begin
                        rdata1_d = '0;
                        resp1_d  = M_AXI_BRESP;
                    end else begin
                        rdata0_d = '0;
                        resp0_d  = M_AXI_BRESP;
                    end
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    if (gnt_q) begin
                        rdata1_d = M_AXI_RDATA;
                        resp1_d  = M_AXI_RRESP;
                    end else begin
                        rdata0_d = M_AXI_RDATA;
                        resp0_d  = M_AXI_RRESP;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            resp0_q   <= 2'b00;
            resp1_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            resp0_q   <= resp0_d;
            resp1_q   <= resp1_d;
        end
    end

    logic unused_we;
    assign unused_we = we_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == RD_ADDR);
    assign M_AXI_RREADY  = (state_q == RD_DATA);

    assign REQ0_DONE  = (state_q == DONE) && !gnt_q;
    assign REQ1_DONE  = (state_q == DONE) &&  gnt_q;
    assign REQ0_RDATA = rdata0_q;
    assign REQ1_RDATA = rdata1_q;
    assign REQ0_RESP  = resp0_q;
    assign REQ1_RESP  = resp1_q;
    assign BUSY       = (state_q != IDLE);

endmodule

// File: doc/axil_reg_arbiter.md
# axil_reg_arbiter

Two-port arbiter and AXI4-Lite master sequencer in front of the `simple_reg` register slave (4 × 32-bit registers). Each requester presents a single-word read or write over a simple valid/done interface. The block grants requesters round-robin and runs exactly one AXI4-Lite transaction at a time. It returns read data and the response code to the granted requester.

## Interface
Parameters:
- C_AXI_ADDR_WIDTH, 4, byte-address width of the slave register space
- C_AXI_DATA_WIDTH, 32, data width; only 32 is supported

Ports (n = 0, 1):
- ACLK  in  1  clock; all logic is on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- REQn_VALID  in  1  request pending; held high until REQn_DONE
- REQn_WE  in  1  1 = write, 0 = read; stable while REQn_VALID is high
- REQn_ADDR  in  C_AXI_ADDR_WIDTH  byte address; bits [1:0] are ignored
- REQn_WDATA  in  32  write data
- REQn_DONE  out  1  one-cycle completion pulse
- REQn_RDATA  out  32  read data; valid while REQn_DONE is high, then held
- REQn_RESP  out  2  BRESP/RRESP of the completed transaction
- BUSY  out  1  high in every state except IDLE
- M_AXI_AWADDR/AWPROT/AWVALID  out; M_AXI_AWREADY  in
- M_AXI_WDATA/WSTRB/WVALID  out; M_AXI_WREADY  in
- M_AXI_BRESP/BVALID  in; M_AXI_BREADY  out
- M_AXI_ARADDR/ARPROT/ARVALID  out; M_AXI_ARREADY  in
- M_AXI_RDATA/RRESP/RVALID  in; M_AXI_RREADY  out

## Operation
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: arbitrate among requesters with REQn_VALID high.
  - Only one requesting: it wins.
  - Both requesting: the requester that was not granted last wins. The pointer resets to "1 was last", so requester 0 wins the first tie.
- On grant, the request is latched: WE, ADDR with [1:0] forced to 00, and WDATA. The FSM then goes to WR_ADDR if WE = 1, else RD_ADDR.
- WR_ADDR:
  - AWVALID and WVALID rise together.
  - Each drops independently in the cycle after its own ready is sampled high.
  - Leave for WR_RESP once both handshakes are complete, including the case where both complete in the same cycle.
- WR_RESP: BREADY is high. On BVALID, capture BRESP and go to DONE.
- RD_ADDR: ARVALID is high. On ARREADY, go to RD_DATA.
- RD_DATA: RREADY is high. On RVALID, capture RDATA and RRESP and go to DONE.
- DONE: pulse REQn_DONE for the granted requester only, update the last-grant pointer, return to IDLE.
- Fixed outputs: AWPROT = ARPROT = 3'b000; WSTRB = 4'hF.
- A requester must not drop REQn_VALID before DONE. A request that drops early is still completed, and its DONE pulse is still issued.
- REQn_RDATA and REQn_RESP are per-port registers. They are updated only on that port's completion; a write completion sets RDATA to 0.

## Timing
- Reset values: all *VALID/*READY outputs 0, DONE 0, BUSY 0, RDATA 0, RESP 2'b00, FSM in IDLE, pointer = 1.
- ARESET assertion mid-transaction clears everything asynchronously and abandons the transaction. The requester must re-present after reset.
- The request is sampled in IDLE. AWVALID/WVALID/ARVALID rise on the next edge; no combinational path from REQ to AXI.
- With a zero-wait slave (ready high, response one cycle after the handshake):
  - write: REQ sampled at edge 0, AW/W valid at edge 1, B valid at edge 2, DONE high at edge 3;
  - read: same 3-cycle latency from sample to DONE.
- Back-to-back operation: the earliest new grant is in the cycle after DONE, so the minimum request-to-request spacing is 4 cycles.
- AXI valid signals never drop before their handshake. No new AW/AR is issued while a response is outstanding.
- REQn_VALID rising in the same cycle as DONE is not arbitrated until IDLE.

## Test plan
- Sequential writes, port 0: addr 0x0/0x4/0x8/0xC with data 1/2/3/4, then reads of the same addresses → RDATA 1/2/3/4, RESP 00, one DONE pulse per request, 3-cycle latency each.
- Tie arbitration: both ports request in the same cycle, port 0 writing 0xA5A5A5A5 to 0x4 and port 1 reading 0x4 → port 0 completes first; port 1 then reads 0xA5A5A5A5.
- Fairness: both ports hold continuous requests for 8 transactions → grant order is 0,1,0,1,…; each port gets exactly 4 DONE pulses.
- Skewed handshakes:
  - AWREADY 3 cycles before WREADY → AWVALID drops first; no duplicate AW; BREADY only after both handshakes.
  - WREADY before AWREADY → mirror behaviour.
- Backpressure and errors: BVALID delayed 10 cycles carrying BRESP = 2'b10 → BUSY is high throughout; REQ0_RESP = 2'b10 at DONE.
- Reset mid-read: assert ARESET while in RD_DATA → ARVALID/RREADY/DONE go to 0 immediately and the FSM is in IDLE. After reset, a re-issued read of 0x8 completes normally.
